// File: rtl/fifo_flags_if.sv
// fifo_flags_if: producer/consumer bundle for fifo_flags (request, data and status flags).
interface fifo_flags_if #(
    parameter int WordLength = 8,
    parameter int AddrBits   = 3
);
    logic                  clr_i;
    logic                  wr_i;
    logic [WordLength-1:0] w_data_i;
    logic                  rd_i;
    logic [WordLength-1:0] r_data_o;
    logic                  empty_o;
    logic                  full_o;
    logic                  almost_empty_o;
    logic                  almost_full_o;
    logic [AddrBits:0]     count_o;
    logic                  overflow_o;
    logic                  underflow_o;

    modport master (
        output clr_i, wr_i, w_data_i, rd_i,
        input  r_data_o, empty_o, full_o, almost_empty_o, almost_full_o, count_o,
               overflow_o, underflow_o
    );

    modport slave (
        input  clr_i, wr_i, w_data_i, rd_i,
        output r_data_o, empty_o, full_o, almost_empty_o, almost_full_o, count_o,
               overflow_o, underflow_o
    );
endinterface

// File: rtl/fifo_flags.sv
// fifo_flags: synchronous FIFO with occupancy count, almost flags, sticky errors, flush and optional FWFT.
module fifo_flags #(
    parameter int WordLength     = 8,
    parameter int AddrBits       = 3,
    parameter int AlmostFullThr  = 6,
    parameter int AlmostEmptyThr = 1,
    parameter bit Fwft           = 1'b0
) (
    input logic        clk_i,
    input logic        rst_i,
    fifo_flags_if.slave bus
);
    localparam logic [AddrBits:0] DepthC = (AddrBits+1)'(2**AddrBits);
    localparam logic [AddrBits:0] AfThr  = (AddrBits+1)'(AlmostFullThr);
    localparam logic [AddrBits:0] AeThr  = (AddrBits+1)'(AlmostEmptyThr);

    logic [WordLength-1:0] mem [2**AddrBits];
    logic [AddrBits-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AddrBits:0]     count_q, count_d;
    logic [WordLength-1:0] r_data_q, r_data_d;
    logic                  ovf_q, ovf_d, udf_q, udf_d;
    logic                  rd_acc, wr_acc;

    always_comb begin
        rd_acc   = bus.rd_i && (count_q != '0);
        // a full FIFO still takes a write when the same edge frees a slot
        wr_acc   = bus.wr_i && ((count_q != DepthC) || rd_acc);
        wr_ptr_d = wr_ptr_q + AddrBits'(wr_acc);
        rd_ptr_d = rd_ptr_q + AddrBits'(rd_acc);
        count_d  = count_q + (AddrBits+1)'(wr_acc) - (AddrBits+1)'(rd_acc);
        ovf_d    = ovf_q | (bus.wr_i & ~wr_acc);
        udf_d    = udf_q | (bus.rd_i & ~rd_acc);
        r_data_d = rd_acc ? mem[rd_ptr_q] : r_data_q;
        if (bus.clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
            r_data_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            r_data_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            r_data_q <= r_data_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_acc && !rst_i && !bus.clr_i) mem[wr_ptr_q] <= bus.w_data_i;
    end

    assign bus.r_data_o       = Fwft ? mem[rd_ptr_q] : r_data_q;
    assign bus.count_o        = count_q;
    assign bus.empty_o        = count_q == '0;
    assign bus.full_o         = count_q == DepthC;
    assign bus.almost_empty_o = count_q <= AeThr;
    assign bus.almost_full_o  = count_q >= AfThr;
    assign bus.overflow_o     = ovf_q;
    assign bus.underflow_o    = udf_q;
endmodule

// File: tb/tb_fifo_flags.sv
// tb_fifo_flags: registered and FWFT instances driven in lockstep and checked against a queue model.
module tb_fifo_flags;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    logic [7:0] q[$];
    logic [7:0] exp_rd;
    logic       exp_ovf, exp_udf;

    always #5 clk = ~clk;

    fifo_flags_if #(.WordLength(8), .AddrBits(3)) bus ();
    fifo_flags_if #(.WordLength(8), .AddrBits(3)) bus2 ();

    assign bus2.clr_i    = bus.clr_i;
    assign bus2.wr_i     = bus.wr_i;
    assign bus2.w_data_i = bus.w_data_i;
    assign bus2.rd_i     = bus.rd_i;

    fifo_flags #(.WordLength(8), .AddrBits(3), .AlmostFullThr(6), .AlmostEmptyThr(1), .Fwft(1'b0))
        dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    fifo_flags #(.WordLength(8), .AddrBits(3), .AlmostFullThr(6), .AlmostEmptyThr(1), .Fwft(1'b1))
        dut_fwft (.clk_i(clk), .rst_i(rst), .bus(bus2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n = q.size();
        chk("count", 32'(bus.count_o), 32'(n));
        chk("empty", 32'(bus.empty_o), 32'(n == 0));
        chk("full", 32'(bus.full_o), 32'(n == 8));
        chk("almost_empty", 32'(bus.almost_empty_o), 32'(n <= 1));
        chk("almost_full", 32'(bus.almost_full_o), 32'(n >= 6));
        chk("overflow", 32'(bus.overflow_o), 32'(exp_ovf));
        chk("underflow", 32'(bus.underflow_o), 32'(exp_udf));
        chk("r_data", 32'(bus.r_data_o), 32'(exp_rd));
        chk("fwft_count", 32'(bus2.count_o), 32'(n));
        chk("fwft_overflow", 32'(bus2.overflow_o), 32'(exp_ovf));
        chk("fwft_underflow", 32'(bus2.underflow_o), 32'(exp_udf));
        if (n > 0) chk("fwft_r_data", 32'(bus2.r_data_o), 32'(q[0]));
    endtask

    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
        logic ra, wa;
        bus.wr_i     = w;
        bus.w_data_i = d;
        bus.rd_i     = r;
        bus.clr_i    = c;
        if (c) begin
            q.delete();
            exp_ovf = 1'b0;
            exp_udf = 1'b0;
            exp_rd  = 8'h00;
        end else begin
            ra = r && (q.size() > 0);
            wa = w && (q.size() < 8 || ra);
            if (ra) exp_rd = q.pop_front();
            if (wa) q.push_back(d);
            if (w && !wa) exp_ovf = 1'b1;
            if (r && !ra) exp_udf = 1'b1;
        end
        @(posedge clk);
        #1;
        check_all();
        bus.wr_i  = 1'b0;
        bus.rd_i  = 1'b0;
        bus.clr_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.clr_i = 1'b0;
        bus.wr_i = 1'b0;
        bus.rd_i = 1'b0;
        bus.w_data_i = 8'h00;
        exp_rd = 8'h00;
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();
        // fill then drain
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        // overflow on full, drain shows no dropped word
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        // underflow alone, then write+read on empty
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        // full with simultaneous write and read
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        // steady occupancy of 3 across pointer wrap
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
        // flush with overflow set at count 5, concurrent write ignored
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b1);
        // FWFT head visible the cycle after the write
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 3);
        // reset mid-stream returns to the reset state
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        exp_rd  = 8'h00;
        check_all();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
